// File: rtl/sprite_pkg.sv
//==============================================================================
// Module      : sprite_pkg
// Description : Shared sprite geometry, ROM types, fetch states and the
//               return-tag layout for the sprite fetch scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package sprite_pkg;

    localparam int SPR_W_C     = 128;
    localparam int SPR_H_C     = 208;
    localparam int ROM_LAT_C   = 2;
    localparam int ROM_WORDS_C = 26624;
    localparam int COL_W_C     = $clog2(SPR_W_C);

    typedef logic [14:0] rom_addr_t;
    typedef logic [31:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic               is_aux;
        logic [COL_W_C-1:0] col;
    } ret_tag_t;

endpackage

`default_nettype wire

// File: rtl/sprite_line_buffer.sv
//==============================================================================
// Module      : sprite_line_buffer
// Description : Ping-pong sprite line buffer, two banks of SPR_W words with one
//               write port and one registered read port (block RAM style).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_line_buffer
    import sprite_pkg::*;
#(
    parameter  int SPR_W = SPR_W_C,
    localparam int COL_W = $clog2(SPR_W)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic             i_wr_bank,
    input  logic [COL_W-1:0] i_wr_col,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_bank,
    input  logic [COL_W-1:0] i_rd_col,
    output logic [31:0]      o_rd_data
);

    pixel_t r_mem [2*SPR_W];
    pixel_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_col}] <= i_wr_data;
        end
        r_rd_data <= r_mem[{i_rd_bank, i_rd_col}];
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sprite_fetch_scheduler.sv
//==============================================================================
// Module      : sprite_fetch_scheduler
// Description : Prefetches the next scanline's sprite row into a ping-pong line
//               buffer, serves pixel lookups and arbitrates spare ROM cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_fetch_scheduler
    import sprite_pkg::*;
#(
    parameter int SPR_W   = SPR_W_C,
    parameter int SPR_H   = SPR_H_C,
    parameter int ROM_LAT = ROM_LAT_C
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_line_start,
    input  logic [9:0]  i_next_y,
    input  logic [9:0]  i_sprite_x,
    input  logic [9:0]  i_sprite_y,
    input  logic [9:0]  i_draw_x,
    output logic        o_rom_rd,
    output logic [14:0] o_rom_addr,
    input  logic [31:0] i_rom_data,
    output logic [31:0] o_pix_data,
    output logic        o_pix_valid,
    input  logic        i_aux_req,
    input  logic [14:0] i_aux_addr,
    output logic        o_aux_gnt,
    output logic        o_aux_rvalid,
    output logic [31:0] o_aux_rdata,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int COL_W  = $clog2(SPR_W);
    localparam int ROW_W  = 15 - COL_W;
    localparam int DCNT_W = $clog2(ROM_LAT + 1);

    fetch_state_t      r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_front_sel;
    logic              r_front_valid;
    logic              r_back_valid;
    logic              r_overrun;
    logic              r_pix_valid;
    ret_tag_t          r_tag [ROM_LAT];

    logic [10:0]       w_row_full;
    logic              w_row_ok;
    logic              w_fetch_rd;
    logic              w_aux_issue;
    logic              w_overrun;
    ret_tag_t          w_tag_in;
    ret_tag_t          w_ret;
    logic              w_wr_en;
    logic [9:0]        w_dx;
    logic              w_pix_hit;
    pixel_t            w_rd_data;

    assign w_row_full = {1'b0, i_next_y} - {1'b0, i_sprite_y};
    assign w_row_ok   = (i_next_y >= i_sprite_y) && (w_row_full < 11'(SPR_H));
    assign w_overrun  = i_line_start && (r_state != IDLE);

    // A line_start during FETCH restarts the row, so that cycle's read is dropped.
    assign w_fetch_rd  = (r_state == FETCH) && !i_line_start;
    assign w_aux_issue = reset_n && (r_state == IDLE) && i_aux_req && !i_line_start;

    assign o_rom_rd   = w_fetch_rd || w_aux_issue;
    assign o_rom_addr = w_fetch_rd  ? {r_row, r_col} :
                        w_aux_issue ? i_aux_addr     : 15'd0;
    assign o_aux_gnt  = w_aux_issue;

    always_comb begin
        w_tag_in        = '0;
        w_tag_in.valid  = o_rom_rd;
        w_tag_in.is_aux = w_aux_issue;
        w_tag_in.col    = COL_W_C'(r_col);
    end

    assign w_ret        = r_tag[ROM_LAT-1];
    assign o_aux_rvalid = w_ret.valid && w_ret.is_aux;
    assign o_aux_rdata  = o_aux_rvalid ? i_rom_data : 32'd0;
    assign w_wr_en      = w_ret.valid && !w_ret.is_aux && !w_overrun;

    // Aux returns survive an overrun; only fetch returns are discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
                if (w_overrun && !r_tag[i-1].is_aux) begin
                    r_tag[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_dcnt        <= '0;
            r_front_sel   <= 1'b0;
            r_front_valid <= 1'b0;
            r_back_valid  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            case (r_state)
                IDLE: begin
                    if (i_line_start) begin
                        r_front_sel   <= ~r_front_sel;
                        r_front_valid <= r_back_valid;
                        r_back_valid  <= 1'b0;
                        if (w_row_ok) begin
                            r_row   <= w_row_full[ROW_W-1:0];
                            r_col   <= '0;
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (i_line_start) begin
                        r_front_valid <= 1'b0;
                        r_back_valid  <= 1'b0;
                        if (w_row_ok) begin
                            r_row   <= w_row_full[ROW_W-1:0];
                            r_col   <= '0;
                            r_state <= FETCH;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_state == FETCH) begin
                        r_col <= r_col + 1'b1;
                        if (r_col == COL_W'(SPR_W - 1)) begin
                            r_dcnt  <= '0;
                            r_state <= DRAIN;
                        end
                    end else if (r_dcnt == DCNT_W'(ROM_LAT - 1)) begin
                        r_back_valid <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_dx      = i_draw_x - i_sprite_x;
    assign w_pix_hit = r_front_valid && (i_draw_x >= i_sprite_x) && (w_dx < 10'(SPR_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_pix_hit;
        end
    end

    sprite_line_buffer #(
        .SPR_W (SPR_W)
    ) u_line_buffer (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (~r_front_sel),
        .i_wr_col  (COL_W'(w_ret.col)),
        .i_wr_data (i_rom_data),
        .i_rd_bank (r_front_sel),
        .i_rd_col  (w_dx[COL_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_valid ? w_rd_data : 32'd0;
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sprite_fetch_scheduler.sv
//==============================================================================
// Module      : tb_sprite_fetch_scheduler
// Description : Self-checking bench for sprite_fetch_scheduler with a ROM model
//               and a line-level reference model of the ping-pong buffers.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_fetch_scheduler;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_line_start = 1'b0;
    logic [9:0]  i_next_y = '0;
    logic [9:0]  i_sprite_x = '0;
    logic [9:0]  i_sprite_y = '0;
    logic [9:0]  i_draw_x = '0;
    logic        o_rom_rd;
    logic [14:0] o_rom_addr;
    logic [31:0] i_rom_data;
    logic [31:0] o_pix_data;
    logic        o_pix_valid;
    logic        i_aux_req = 1'b0;
    logic [14:0] i_aux_addr = '0;
    logic        o_aux_gnt;
    logic        o_aux_rvalid;
    logic [31:0] o_aux_rdata;
    logic        o_busy;
    logic        o_overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sprite_fetch_scheduler u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_line_start (i_line_start),
        .i_next_y     (i_next_y),
        .i_sprite_x   (i_sprite_x),
        .i_sprite_y   (i_sprite_y),
        .i_draw_x     (i_draw_x),
        .o_rom_rd     (o_rom_rd),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_pix_data   (o_pix_data),
        .o_pix_valid  (o_pix_valid),
        .i_aux_req    (i_aux_req),
        .i_aux_addr   (i_aux_addr),
        .o_aux_gnt    (o_aux_gnt),
        .o_aux_rvalid (o_aux_rvalid),
        .o_aux_rdata  (o_aux_rdata),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    function automatic logic [31:0] rom_word(input logic [14:0] a);
        return {a, 17'h0} ^ (32'h9E3779B9 * {17'h0, a});
    endfunction

    // Two-stage pipelined ROM; unread cycles return a marker value.
    logic [31:0] r_rom_p1, r_rom_p2;
    always @(posedge clk) begin
        r_rom_p1 <= o_rom_rd ? rom_word(o_rom_addr) : 32'hDEADBEEF;
        r_rom_p2 <= r_rom_p1;
    end
    assign i_rom_data = r_rom_p2;

    logic [14:0] fetch_q[$];
    int          busy_cnt = 0;
    int          gnt_cnt  = 0;
    always @(negedge clk) begin
        if (o_rom_rd && !o_aux_gnt) fetch_q.push_back(o_rom_addr);
        if (o_busy) busy_cnt++;
        if (o_aux_gnt) gnt_cnt++;
    end

    // Reference model: which sprite row each buffer holds and whether it is usable.
    bit m_front_valid = 0;
    bit m_back_valid  = 0;
    int m_front_row   = 0;
    int m_back_row    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input int row, input int start);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (int'(fetch_q[start + i]) != row * 128 + i) bad++;
        end
        chk("fetch_first_addr", 32'(fetch_q[start]), 32'(row * 128));
        chk("fetch_last_addr", 32'(fetch_q[start + 127]), 32'(row * 128 + 127));
        chk("fetch_addr_seq", 32'(bad), 32'd0);
    endtask

    task automatic run_line(input int ny, input int sy, input int sx);
        int row;
        bit ok;
        int n;
        row = ny - sy;
        ok  = (ny >= sy) && (row < SPR_H_C);
        fetch_q.delete();
        busy_cnt = 0;
        i_next_y = 10'(ny);
        i_sprite_y = 10'(sy);
        i_sprite_x = 10'(sx);
        i_line_start = 1'b1;
        #1;
        chk("line_beats_aux", 32'(o_aux_gnt), 32'd0);
        step();
        i_line_start = 1'b0;
        n = 0;
        while (o_busy && n < 400) begin
            step();
            n++;
        end
        chk("fetch_timeout", 32'(o_busy), 32'd0);
        m_front_valid = m_back_valid;
        m_front_row   = m_back_row;
        m_back_valid  = 0;
        if (ok) begin
            m_back_valid = 1;
            m_back_row   = row;
        end
        chk("fetch_count", 32'(fetch_q.size()), ok ? 32'd128 : 32'd0);
        chk("busy_cycles", 32'(busy_cnt), ok ? 32'd130 : 32'd0);
        if (ok && fetch_q.size() == 128) check_seq(row, 0);
    endtask

    task automatic pix(input string tag, input int dx);
        logic [9:0]  d10;
        int          rel;
        int          sx;
        bit          v;
        logic [31:0] d;
        d10 = 10'(dx);
        sx  = int'(i_sprite_x);
        rel = int'(d10) - sx;
        v   = m_front_valid && (int'(d10) >= sx) && (rel < 128);
        d   = v ? rom_word(15'(m_front_row * 128 + rel)) : 32'd0;
        i_draw_x = d10;
        step();
        chk({tag, "_valid"}, 32'(o_pix_valid), 32'(v));
        chk({tag, "_data"}, o_pix_data, d);
    endtask

    task automatic aux_read(input logic [14:0] a, input int max_wait, output int waited);
        i_aux_req  = 1'b1;
        i_aux_addr = a;
        #1;
        waited = 0;
        while (!o_aux_gnt && waited < max_wait) begin
            step();
            waited++;
        end
        chk("aux_gnt", 32'(o_aux_gnt), 32'd1);
        step();
        i_aux_req = 1'b0;
        chk("aux_rvalid_early", 32'(o_aux_rvalid), 32'd0);
        step();
        chk("aux_rvalid", 32'(o_aux_rvalid), 32'd1);
        chk("aux_rdata", o_aux_rdata, rom_word(a));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int cnt;
        int sy;
        int ny;
        int sx;

        #1;
        chk("rst_rom_rd", 32'(o_rom_rd), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_pix_valid", 32'(o_pix_valid), 32'd0);
        chk("rst_aux_rvalid", 32'(o_aux_rvalid), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        run_line(10, 10, 100);
        run_line(11, 10, 100);
        pix("px_left", 100);
        pix("px_right", 227);
        pix("px_before", 99);
        pix("px_after", 228);

        run_line(217, 10, 100);
        pix("px_row1", 150);
        run_line(218, 10, 100);
        pix("px_row207_l", 100);
        pix("px_row207_r", 227);
        run_line(5, 10, 100);
        pix("px_front_empty", 120);

        aux_read(15'h1234, 4, w);
        chk("aux_gnt_latency", 32'(w), 32'd0);

        i_aux_req  = 1'b1;
        i_aux_addr = 15'h0777;
        gnt_cnt    = 0;
        run_line(30, 10, 100);
        chk("aux_gnt_during_fetch", 32'(gnt_cnt), 32'd0);
        aux_read(15'h0777, 4, w);
        chk("aux_after_drain", 32'(w), 32'd0);

        // Overrun: interrupt a fetch 50 cycles in.
        fetch_q.delete();
        i_next_y = 10'd40;
        i_line_start = 1'b1;
        step();
        i_line_start = 1'b0;
        m_front_valid = m_back_valid;
        m_front_row   = m_back_row;
        repeat (50) step();
        chk("busy_before_overrun", 32'(o_busy), 32'd1);
        i_next_y = 10'd41;
        i_line_start = 1'b1;
        step();
        i_line_start = 1'b0;
        chk("overrun_pulse", 32'(o_overrun), 32'd1);
        m_front_valid = 0;
        m_back_valid  = 0;
        pix("px_after_overrun", 110);
        chk("overrun_one_cycle", 32'(o_overrun), 32'd0);
        cnt = 0;
        while (o_busy && cnt < 400) begin
            step();
            cnt++;
        end
        chk("overrun_fetch_timeout", 32'(o_busy), 32'd0);
        chk("overrun_rd_total", 32'(fetch_q.size()), 32'd178);
        if (fetch_q.size() == 178) begin
            chk("overrun_old_last", 32'(fetch_q[49]), 32'(30 * 128 + 49));
            check_seq(31, 50);
        end
        m_back_valid = 1;
        m_back_row   = 31;
        run_line(42, 10, 100);
        pix("px_ovr_row_l", 100);
        pix("px_ovr_row_r", 227);

        // Reset in the middle of a fetch, with an aux request pending.
        i_next_y = 10'd20;
        i_line_start = 1'b1;
        step();
        i_line_start = 1'b0;
        repeat (20) step();
        chk("busy_mid_fetch", 32'(o_busy), 32'd1);
        i_aux_req  = 1'b1;
        i_aux_addr = 15'h0100;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rom_rd", 32'(o_rom_rd), 32'd0);
        chk("mid_rst_rom_addr", 32'(o_rom_addr), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_aux_gnt", 32'(o_aux_gnt), 32'd0);
        chk("mid_rst_pix", 32'(o_pix_valid), 32'd0);
        chk("mid_rst_overrun", 32'(o_overrun), 32'd0);
        chk("mid_rst_aux_rvalid", 32'(o_aux_rvalid), 32'd0);
        repeat (3) step();
        i_aux_req = 1'b0;
        reset_n = 1'b1;
        m_front_valid = 0;
        m_back_valid  = 0;
        cnt = 0;
        repeat (6) begin
            step();
            if (o_rom_rd || o_aux_rvalid || o_busy) cnt++;
        end
        chk("post_reset_quiet", 32'(cnt), 32'd0);

        // Reset while an aux read is in flight.
        i_aux_req  = 1'b1;
        i_aux_addr = 15'h0200;
        #1;
        chk("aux_gnt_pre_reset", 32'(o_aux_gnt), 32'd1);
        step();
        i_aux_req = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            if (o_aux_rvalid) cnt++;
            step();
        end
        chk("no_stale_aux_rvalid", 32'(cnt), 32'd0);
        pix("px_after_reset", 100);

        for (int it = 0; it < 12; it++) begin
            sy = int'($urandom_range(20, 400));
            ny = sy + int'($urandom_range(0, 240)) - 20;
            sx = int'($urandom_range(0, 700));
            run_line(ny, sy, sx);
            if ($urandom_range(0, 1) == 1) begin
                aux_read(15'($urandom_range(0, ROM_WORDS_C - 1)), 4, w);
            end
            pix("rnd_edge_lo", sx - 1);
            pix("rnd_first", sx);
            pix("rnd_mid", sx + int'($urandom_range(1, 126)));
            pix("rnd_last", sx + 127);
            pix("rnd_edge_hi", sx + 128);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
